// File: rtl/mac_header_parser.sv
// Per-port header parser: pulls destination/source MACs out of the ingress byte stream and
// issues a one-cycle learn strobe plus a held lookup request for each complete header.
module mac_header_parser #(
   parameter int unsigned ADDR_W = 49,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              rx_sof,
   input  logic              rx_eof,
   output logic              source_address_valid_o,
   output logic [ADDR_W-1:0] source_address_o,
   output logic              read_en_o,
   output logic [ADDR_W-1:0] read_address_o,
   input  logic              read_ready_i,
   output logic              dest_multicast_o,
   output logic [CNT_W-1:0]  runt_count_o,
   output logic [CNT_W-1:0]  drop_count_o
);

   typedef enum logic [1:0] {StIdle, StHdr, StPayload} state_e;

   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [87:0] hdr_q, hdr_d;
   logic [95:0] hdr_shift;
   logic        hdr_done, runt_inc, drop_inc;

   logic             sav_q, sav_d;
   logic [47:0]      src_q, src_d;
   logic             rd_en_q, rd_en_d;
   logic [47:0]      rd_addr_q, rd_addr_d;
   logic             mc_q, mc_d;
   logic [CNT_W-1:0] runt_q, runt_d, drop_q, drop_d;

   // Oldest byte ends up in [95:88], so a full header is {dest, src} in wire order.
   assign hdr_shift = {hdr_q, rx_data};

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      hdr_d    = hdr_q;
      hdr_done = 1'b0;
      runt_inc = 1'b0;
      if (rx_valid) begin
         unique case (state_q)
            StIdle: begin
               if (rx_sof) begin
                  hdr_d = hdr_shift[87:0];
                  if (rx_eof) begin
                     runt_inc = 1'b1;
                  end else begin
                     state_d = StHdr;
                     idx_d   = 4'd1;
                  end
               end
            end
            StHdr, StPayload: begin
               if (rx_sof) begin
                  // Restart on a new sof; abandoning a partial header is a runt.
                  hdr_d    = hdr_shift[87:0];
                  runt_inc = (state_q == StHdr) || rx_eof;
                  if (rx_eof) begin
                     state_d = StIdle;
                     idx_d   = 4'd0;
                  end else begin
                     state_d = StHdr;
                     idx_d   = 4'd1;
                  end
               end else if (state_q == StHdr) begin
                  hdr_d = hdr_shift[87:0];
                  if (idx_q == 4'd11) begin
                     hdr_done = 1'b1;
                     idx_d    = 4'd0;
                     state_d  = rx_eof ? StIdle : StPayload;
                  end else if (rx_eof) begin
                     runt_inc = 1'b1;
                     idx_d    = 4'd0;
                     state_d  = StIdle;
                  end else begin
                     idx_d = idx_q + 4'd1;
                  end
               end else if (rx_eof) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      sav_d     = 1'b0;
      src_d     = src_q;
      rd_en_d   = rd_en_q;
      rd_addr_d = rd_addr_q;
      mc_d      = mc_q;
      drop_inc  = 1'b0;
      if (rd_en_q && read_ready_i) begin
         rd_en_d = 1'b0;
      end
      if (hdr_done) begin
         if (!hdr_shift[40]) begin
            sav_d = 1'b1;
            src_d = hdr_shift[47:0];
         end
         if (!rd_en_q || read_ready_i) begin
            rd_en_d   = 1'b1;
            rd_addr_d = hdr_shift[95:48];
            mc_d      = hdr_shift[88];
         end else begin
            drop_inc = 1'b1;
         end
      end
      runt_d = (runt_inc && (runt_q != '1)) ? runt_q + CNT_W'(1) : runt_q;
      drop_d = (drop_inc && (drop_q != '1)) ? drop_q + CNT_W'(1) : drop_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         idx_q     <= 4'd0;
         hdr_q     <= '0;
         sav_q     <= 1'b0;
         src_q     <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         mc_q      <= 1'b0;
         runt_q    <= '0;
         drop_q    <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         hdr_q     <= hdr_d;
         sav_q     <= sav_d;
         src_q     <= src_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         mc_q      <= mc_d;
         runt_q    <= runt_d;
         drop_q    <= drop_d;
      end
   end

   assign source_address_valid_o = sav_q;
   assign source_address_o       = ADDR_W'(src_q);
   assign read_en_o              = rd_en_q;
   assign read_address_o         = ADDR_W'(rd_addr_q);
   assign dest_multicast_o       = mc_q;
   assign runt_count_o           = runt_q;
   assign drop_count_o           = drop_q;

endmodule

// File: doc/mac_header_parser.md
# mac_header_parser

Per-port ingress stage feeding the address learning and lookup logic of the switch. Consumes one port's received byte stream and extracts the 6-byte destination and source MAC addresses from each frame header. Emits a one-cycle learn request (source address) toward `address_learn`, and a held lookup request (destination address) toward the shared `address_read` port. One instance per switch port.

## Interface
Parameters:
- `ADDR_W`, 49: width of an address word as used by the address table; bits [47:0] carry the MAC, bits above 47 driven 0.
- `CNT_W`, 16: width of the saturating runt/drop counters.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: byte on `rx_data` is valid this cycle.
- `rx_data` in 8: received byte, wire order.
- `rx_sof` in 1: qualifies the first byte of a frame (only meaningful with `rx_valid`).
- `rx_eof` in 1: qualifies the last byte of a frame (only meaningful with `rx_valid`).
- `source_address_valid_o` out 1: one-cycle learn strobe.
- `source_address_o` out ADDR_W: source MAC to learn.
- `read_en_o` out 1: lookup request, held until accepted.
- `read_address_o` out ADDR_W: destination MAC to look up.
- `read_ready_i` in 1: lookup port accepts request this cycle when high with `read_en_o`.
- `dest_multicast_o` out 1: I/G bit of the pending lookup's destination; valid while `read_en_o`.
- `runt_count_o` out CNT_W: frames ended or aborted before 12 header bytes.
- `drop_count_o` out CNT_W: lookups discarded because the previous lookup was still pending.

## Operation
- FSM states: IDLE, HDR, PAYLOAD. Byte index counter 0..11 (4 bits).
- IDLE: waits for `rx_valid & rx_sof`. That byte is index 0 -> HDR. Valid bytes without sof in IDLE are ignored.
- HDR: each valid byte shifts into a 96-bit header register. The first wire byte lands in dest[47:40]; byte 5 lands in dest[7:0]; bytes 6..11 fill src[47:0] the same way.
- On accepting index 11 (without eof): go to PAYLOAD and issue requests (see below).
- Index 11 accepted with eof: issue requests and go to IDLE.
- PAYLOAD: ignore data until `rx_valid & rx_eof` -> IDLE.
- Runt: `rx_eof` on index <11 in HDR -> IDLE, `runt_count_o` += 1, no requests.
- Abort: `rx_sof` while in HDR or PAYLOAD restarts at index 0 in HDR. This counts as a runt only if it occurred in HDR.
- A byte with both sof and eof is a 1-byte runt.
- Learn: `source_address_valid_o` pulses once per complete header unless src[40] (I/G bit, LSB of wire byte 6) = 1. A multicast source is never learned.
- Lookup: `read_en_o` asserts with `read_address_o` = {0, dest} and `dest_multicast_o` = dest[40]. Stays asserted with stable address until the cycle `read_en_o & read_ready_i`, then deasserts next cycle.
- If a new header completes while a lookup is still pending, the new lookup is discarded (pending one kept) and `drop_count_o` += 1. Learn for the new frame still issues.
- If a header completes in the same cycle the pending lookup is accepted, the new lookup loads and `read_en_o` stays high; no drop.
- Counters saturate at all-ones.

## Timing
- Reset values: state IDLE, index 0, all outputs 0 (`source_address_valid_o`, `source_address_o`, `read_en_o`, `read_address_o`, `dest_multicast_o`, both counters).
- Latency: index-11 byte sampled at edge N; `source_address_valid_o` and `read_en_o` high during cycle N+1 (registered).
- `source_address_o` holds its value after the pulse until the next learn.
- `rx_valid` may gap arbitrarily mid-header; the index advances only on valid bytes.
- Reset mid-frame or mid-lookup clears all state immediately; a pending lookup is lost, never re-issued.
- Back-to-back frames: sof is accepted in the cycle directly after eof.

## Test plan
- Frame with dest 00:11:22:33:44:55, src 02:AA:BB:CC:DD:EE, 64 bytes, `read_ready_i`=1 -> one learn pulse with src 0x02AABBCCDDEE. `read_en_o` high exactly one cycle with 0x001122334455, `dest_multicast_o`=0, both counters 0.
- Source 01:00:5E:00:00:01 -> no learn pulse; lookup still issued.
- Dest FF:FF:FF:FF:FF:FF -> lookup issued with `dest_multicast_o`=1.
- 8-byte frame (eof on index 7) -> no outputs, `runt_count_o`=1. Then sof at index 4 of the next frame, followed by a full frame -> `runt_count_o`=2, and the full frame's requests are correct.
- `read_ready_i` held 0 across two full frames -> first lookup address held stable, `drop_count_o`=1, two learn pulses. Raise ready -> handshake completes, `read_en_o` falls next cycle.
- Reset asserted while `read_en_o` is pending -> all outputs 0 asynchronously. After release, no request until a new sof.
